// File: rtl/usb4_lane_pkg.sv
// rtl/usb4_lane_pkg.sv - USB4 lane-0 ordered-set codes, header constants and PRBS11 parameters
package usb4_lane_pkg;

  localparam logic [3:0] OS_SLOS1   = 4'd0;
  localparam logic [3:0] OS_SLOS2   = 4'd1;
  localparam logic [3:0] OS_TS1_G3  = 4'd2;
  localparam logic [3:0] OS_TS2_G3  = 4'd3;
  localparam logic [3:0] OS_TS1_G4  = 4'd4;
  localparam logic [3:0] OS_TS2_G4  = 4'd5;
  localparam logic [3:0] OS_TS3_G4  = 4'd6;
  localparam logic [3:0] OS_TS4_G4  = 4'd7;
  localparam logic [3:0] OS_NONE    = 4'hF;

  localparam logic [63:0] TS1_GEN3      = 64'h01010000000064F2;
  localparam logic [63:0] TS2_GEN3      = 64'h01000000000064F2;
  localparam logic [31:0] TS1_GEN4      = 32'h7E02D0F0;
  localparam logic [31:0] TS2_GEN4      = 32'h7E04B0F0;
  localparam logic [31:0] TS3_GEN4      = 32'h7E0690F0;
  localparam logic [31:0] TS4_GEN4_BASE = 32'h7E0F0000;

  localparam logic [10:0] PRBS11_SEED  = 11'b10000000000;
  localparam int          PRBS11_TAP_A = 10;
  localparam int          PRBS11_TAP_B = 8;

  // TS4 carries its counter N in byte 1 and the complement 4'hF-N in the top nibble of byte 0.
  function automatic logic ts4_match(input logic [31:0] w);
    logic [3:0] n;
    n = w[11:8];
    return (w[31:16] == TS4_GEN4_BASE[31:16]) && (w[15:12] == 4'h0) &&
           (n != 4'h0) && (w[7:0] == {4'hF - n, 4'h0});
  endfunction

endpackage

// File: rtl/prbs11_checker.sv
// rtl/prbs11_checker.sv - self-synchronising PRBS11 checker for SLOS1 (true) and SLOS2 (inverted)
module prbs11_checker import usb4_lane_pkg::*; #(
  parameter logic [10:0] SEED       = PRBS11_SEED,
  parameter int          LOCK_BYTES = 4,
  parameter int          SLOS_BYTES = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_en,
  input  logic       clear,
  output logic       slos1_lock,
  output logic       slos2_lock,
  output logic       report,
  output logic       err
);

  localparam int CW = $clog2(LOCK_BYTES + 1);
  localparam int PW = $clog2(SLOS_BYTES);

  logic [10:0]   hist_q, hist_d;
  logic [3:0]    fill_q, fill_d;
  logic [CW-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic          lock1_q, lock1_d, lock2_q, lock2_d;
  logic [PW-1:0] period_q, period_d;

  logic [10:0] h;
  logic [3:0]  f;
  logic        ok1, ok2, tap, full;

  always_comb begin
    hist_d   = hist_q;
    fill_d   = fill_q;
    cnt1_d   = cnt1_q;
    cnt2_d   = cnt2_q;
    lock1_d  = lock1_q;
    lock2_d  = lock2_q;
    period_d = period_q;
    report   = 1'b0;
    err      = 1'b0;
    h        = hist_q;
    f        = fill_q;
    ok1      = 1'b1;
    ok2      = 1'b1;
    tap      = 1'b0;
    full     = (fill_q == 4'd11);
    if (clear) begin
      hist_d   = SEED;
      fill_d   = '0;
      cnt1_d   = '0;
      cnt2_d   = '0;
      lock1_d  = 1'b0;
      lock2_d  = 1'b0;
      period_d = '0;
    end else if (rx_en) begin
      for (int i = 7; i >= 0; i--) begin
        if (f < 4'd11) begin
          f = f + 4'd1;
        end else begin
          tap = h[PRBS11_TAP_A] ^ h[PRBS11_TAP_B];
          if (rx_byte[i] != tap) ok1 = 1'b0;
          if (rx_byte[i] == tap) ok2 = 1'b0;
        end
        h = {h[9:0], rx_byte[i]};
      end
      hist_d = h;
      fill_d = f;
      // A constant history satisfies the recurrence trivially and must never count as lock.
      if (!ok1 || h == 11'h000) begin
        err     = lock1_q && !ok1;
        cnt1_d  = '0;
        lock1_d = 1'b0;
      end else if (full) begin
        if (lock1_q) begin
          if (period_q == PW'(SLOS_BYTES - 1)) begin
            report   = 1'b1;
            period_d = '0;
          end else begin
            period_d = period_q + 1'b1;
          end
        end else if (cnt1_q == CW'(LOCK_BYTES - 1)) begin
          report   = 1'b1;
          lock1_d  = 1'b1;
          cnt1_d   = cnt1_q + 1'b1;
          period_d = '0;
        end else begin
          cnt1_d = cnt1_q + 1'b1;
        end
      end
      if (!ok2 || h == 11'h7FF) begin
        err     = err | (lock2_q && !ok2);
        cnt2_d  = '0;
        lock2_d = 1'b0;
      end else if (full) begin
        if (lock2_q) begin
          if (period_q == PW'(SLOS_BYTES - 1)) begin
            report   = 1'b1;
            period_d = '0;
          end else begin
            period_d = period_q + 1'b1;
          end
        end else if (cnt2_q == CW'(LOCK_BYTES - 1)) begin
          report   = 1'b1;
          lock2_d  = 1'b1;
          cnt2_d   = cnt2_q + 1'b1;
          period_d = '0;
        end else begin
          cnt2_d = cnt2_q + 1'b1;
        end
      end
    end
  end

  assign slos1_lock = lock1_d;
  assign slos2_lock = lock2_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q   <= SEED;
      fill_q   <= '0;
      cnt1_q   <= '0;
      cnt2_q   <= '0;
      lock1_q  <= 1'b0;
      lock2_q  <= 1'b0;
      period_q <= '0;
    end else begin
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      cnt1_q   <= cnt1_d;
      cnt2_q   <= cnt2_d;
      lock1_q  <= lock1_d;
      lock2_q  <= lock2_d;
      period_q <= period_d;
    end
  end

endmodule

// File: rtl/data_bus_receive.sv
// rtl/data_bus_receive.sv - USB4 lane-0 receive path: ordered-set detection and data-mode forwarding
module data_bus_receive import usb4_lane_pkg::*; #(
  parameter logic [10:0] SEED            = PRBS11_SEED,
  parameter int          PRBS_LOCK_BYTES = 4,
  parameter int          SLOS_BYTES      = 256
) (
  input  logic       fsm_clk,
  input  logic       rst,
  input  logic [7:0] lane_0_rx,
  input  logic       lane_0_rx_en,
  input  logic       gen4_mode,
  input  logic       data_mode,
  output logic [3:0] os_in,
  output logic       os_valid,
  output logic [3:0] ts4_index,
  output logic       prbs_err,
  output logic [7:0] transport_layer_data_out,
  output logic       transport_data_valid
);

  // Only 56 bits are stored; the 64-bit window is always {stored, incoming byte}.
  logic [55:0] win_q, win_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gen4_q, gen4_d;
  logic [3:0]  os_in_q, os_in_d;
  logic        os_valid_q, os_valid_d;
  logic [3:0]  ts4_q, ts4_d;
  logic        prbs_err_q, prbs_err_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;

  logic [63:0] win_full;
  logic [3:0]  base_cnt, cnt_inc, ts_code;
  logic        ts_hit;
  logic        chk_slos1_lock, chk_slos2_lock, chk_report, chk_err;

  prbs11_checker #(
    .SEED       (SEED),
    .LOCK_BYTES (PRBS_LOCK_BYTES),
    .SLOS_BYTES (SLOS_BYTES)
  ) u_prbs11_checker (
    .clk        (fsm_clk),
    .rst_n      (rst),
    .rx_byte    (lane_0_rx),
    .rx_en      (lane_0_rx_en),
    .clear      (data_mode),
    .slos1_lock (chk_slos1_lock),
    .slos2_lock (chk_slos2_lock),
    .report     (chk_report),
    .err        (chk_err)
  );

  always_comb begin
    win_full = {win_q, lane_0_rx};
    base_cnt = (gen4_mode != gen4_q) ? 4'd0 : cnt_q;
    cnt_inc  = (base_cnt == 4'd8) ? 4'd8 : base_cnt + 4'd1;
    ts_hit   = 1'b0;
    ts_code  = OS_NONE;
    if (!gen4_mode) begin
      if (cnt_inc == 4'd8) begin
        if (win_full == TS1_GEN3) begin
          ts_hit = 1'b1; ts_code = OS_TS1_G3;
        end else if (win_full == TS2_GEN3) begin
          ts_hit = 1'b1; ts_code = OS_TS2_G3;
        end
      end
    end else if (cnt_inc >= 4'd4) begin
      if (win_full[31:0] == TS1_GEN4) begin
        ts_hit = 1'b1; ts_code = OS_TS1_G4;
      end else if (win_full[31:0] == TS2_GEN4) begin
        ts_hit = 1'b1; ts_code = OS_TS2_G4;
      end else if (win_full[31:0] == TS3_GEN4) begin
        ts_hit = 1'b1; ts_code = OS_TS3_G4;
      end else if (ts4_match(win_full[31:0])) begin
        ts_hit = 1'b1; ts_code = OS_TS4_G4;
      end
    end
  end

  always_comb begin
    win_d      = win_q;
    cnt_d      = base_cnt;
    gen4_d     = gen4_mode;
    os_in_d    = os_in_q;
    os_valid_d = 1'b0;
    ts4_d      = ts4_q;
    prbs_err_d = 1'b0;
    tdata_d    = tdata_q;
    tvalid_d   = 1'b0;
    if (data_mode) begin
      win_d = '0;
      cnt_d = '0;
      if (lane_0_rx_en) begin
        tdata_d  = lane_0_rx;
        tvalid_d = 1'b1;
      end
    end else if (lane_0_rx_en) begin
      win_d      = win_full[55:0];
      cnt_d      = cnt_inc;
      prbs_err_d = chk_err;
      // Clearing the count on a match forces the next ordered set to arrive in full.
      if (ts_hit) begin
        os_valid_d = 1'b1;
        os_in_d    = ts_code;
        cnt_d      = '0;
        if (ts_code == OS_TS4_G4) ts4_d = win_full[11:8];
      end else if (chk_report && chk_slos1_lock) begin
        os_valid_d = 1'b1;
        os_in_d    = OS_SLOS1;
      end else if (chk_report && chk_slos2_lock) begin
        os_valid_d = 1'b1;
        os_in_d    = OS_SLOS2;
      end
    end
  end

  always_ff @(posedge fsm_clk or negedge rst) begin
    if (!rst) begin
      win_q      <= '0;
      cnt_q      <= '0;
      gen4_q     <= 1'b0;
      os_in_q    <= OS_NONE;
      os_valid_q <= 1'b0;
      ts4_q      <= '0;
      prbs_err_q <= 1'b0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
    end else begin
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      gen4_q     <= gen4_d;
      os_in_q    <= os_in_d;
      os_valid_q <= os_valid_d;
      ts4_q      <= ts4_d;
      prbs_err_q <= prbs_err_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
    end
  end

  assign os_in                    = os_in_q;
  assign os_valid                 = os_valid_q;
  assign ts4_index                = ts4_q;
  assign prbs_err                 = prbs_err_q;
  assign transport_layer_data_out = tdata_q;
  assign transport_data_valid     = tvalid_q;

endmodule

// File: tb/tb_data_bus_receive.sv
// tb/tb_data_bus_receive.sv - directed self-checking bench for data_bus_receive
module tb_data_bus_receive;

  logic       fsm_clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] lane_0_rx = 8'h00;
  logic       lane_0_rx_en = 1'b0;
  logic       gen4_mode = 1'b0;
  logic       data_mode = 1'b0;
  logic [3:0] os_in;
  logic       os_valid;
  logic [3:0] ts4_index;
  logic       prbs_err;
  logic [7:0] transport_layer_data_out;
  logic       transport_data_valid;

  data_bus_receive dut (
    .fsm_clk                  (fsm_clk),
    .rst                      (rst),
    .lane_0_rx                (lane_0_rx),
    .lane_0_rx_en             (lane_0_rx_en),
    .gen4_mode                (gen4_mode),
    .data_mode                (data_mode),
    .os_in                    (os_in),
    .os_valid                 (os_valid),
    .ts4_index                (ts4_index),
    .prbs_err                 (prbs_err),
    .transport_layer_data_out (transport_layer_data_out),
    .transport_data_valid     (transport_data_valid)
  );

  always #5 fsm_clk = ~fsm_clk;

  int         n_checks = 0;
  int         n_pass = 0;
  int         ov_count, ov_first, ov_last, err_count, err_first;
  logic [3:0] ov_code, ov_ts4_first, ov_ts4_last;
  logic [7:0] seq [0:63];
  logic [7:0] prbs [0:63];
  logic       bits [0:511];
  logic [10:0] seed_v;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    lane_0_rx_en = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge fsm_clk);
    rst = 1'b1;
    @(negedge fsm_clk);
  endtask

  // Strobe one byte, then sample the one-cycle pulses at the following negedge.
  task automatic send_byte(input logic [7:0] b, input int idx);
    @(negedge fsm_clk);
    lane_0_rx = b;
    lane_0_rx_en = 1'b1;
    @(negedge fsm_clk);
    lane_0_rx_en = 1'b0;
    if (os_valid) begin
      ov_count = ov_count + 1;
      if (ov_first == 0) begin
        ov_first = idx;
        ov_ts4_first = ts4_index;
      end
      ov_last = idx;
      ov_code = os_in;
      ov_ts4_last = ts4_index;
    end
    if (prbs_err) begin
      err_count = err_count + 1;
      if (err_first == 0) err_first = idx;
    end
  endtask

  task automatic run_seq(input int len);
    ov_count = 0; ov_first = 0; ov_last = 0; err_count = 0; err_first = 0;
    ov_code = 4'hF; ov_ts4_first = 4'h0; ov_ts4_last = 4'h0;
    for (int i = 0; i < len; i++) send_byte(seq[i], i + 1);
  endtask

  task automatic load8(input logic [63:0] v);
    for (int i = 0; i < 8; i++) seq[i] = v[63 - 8*i -: 8];
  endtask

  initial begin
    seed_v = 11'b10000000000;
    for (int i = 0; i < 11; i++) bits[i] = seed_v[10 - i];
    for (int n = 11; n < 512; n++) bits[n] = bits[n - 11] ^ bits[n - 9];
    for (int k = 0; k < 64; k++)
      for (int j = 0; j < 8; j++) prbs[k][7 - j] = bits[8*k + j];

    do_reset();
    check("rst_os_in", os_in, 4'hF);
    check("rst_os_valid", os_valid, 0);
    check("rst_ts4_index", ts4_index, 0);
    check("rst_prbs_err", prbs_err, 0);
    check("rst_tl_data", transport_layer_data_out, 0);
    check("rst_tl_valid", transport_data_valid, 0);

    // Gen3 TS1 then TS2
    load8(64'h01010000000064F2);
    run_seq(8);
    check("g3_ts1_count", ov_count, 1);
    check("g3_ts1_byte", ov_last, 8);
    check("g3_ts1_code", ov_code, 2);
    load8(64'h01000000000064F2);
    run_seq(8);
    check("g3_ts2_count", ov_count, 1);
    check("g3_ts2_byte", ov_last, 8);
    check("g3_ts2_code", ov_code, 3);

    // Gen4 TS4 N=1 and N=15, bad TS4, then Gen4 TS1
    gen4_mode = 1'b1;
    do_reset();
    load8(64'h7E0F01E07E0F0F00);
    run_seq(8);
    check("g4_ts4_count", ov_count, 2);
    check("g4_ts4_first_byte", ov_first, 4);
    check("g4_ts4_first_idx", ov_ts4_first, 1);
    check("g4_ts4_last_idx", ov_ts4_last, 15);
    check("g4_ts4_code", ov_code, 7);
    seq[0] = 8'h7E; seq[1] = 8'h0F; seq[2] = 8'h03; seq[3] = 8'hE0;
    run_seq(4);
    check("g4_ts4_bad_count", ov_count, 0);
    check("g4_ts4_idx_held", ts4_index, 15);
    seq[0] = 8'h7E; seq[1] = 8'h02; seq[2] = 8'hD0; seq[3] = 8'hF0;
    run_seq(4);
    check("g4_ts1_count", ov_count, 1);
    check("g4_ts1_code", ov_code, 4);

    // SLOS1, SLOS2, all-zero
    gen4_mode = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) seq[i] = prbs[i];
    run_seq(20);
    check("slos1_count", ov_count, 1);
    check("slos1_byte", ov_first, 6);
    check("slos1_code", ov_code, 0);
    check("slos1_err", err_count, 0);
    do_reset();
    for (int i = 0; i < 20; i++) seq[i] = ~prbs[i];
    run_seq(20);
    check("slos2_count", ov_count, 1);
    check("slos2_byte", ov_first, 6);
    check("slos2_code", ov_code, 1);
    do_reset();
    for (int i = 0; i < 20; i++) seq[i] = 8'h00;
    run_seq(20);
    check("zeros_count", ov_count, 0);

    // Locked SLOS1 with the first bit of byte 40 flipped
    do_reset();
    for (int i = 0; i < 50; i++) seq[i] = prbs[i];
    seq[39] = seq[39] ^ 8'h80;
    run_seq(50);
    check("err_count", err_count, 1);
    check("err_byte", err_first, 40);
    check("relock_count", ov_count, 2);
    check("relock_first", ov_first, 6);
    check("relock_byte", ov_last, 45);
    check("relock_code", ov_code, 0);

    // Data mode forwarding, TS suppressed, clean restart on exit
    do_reset();
    data_mode = 1'b1;
    send_byte(8'hA5, 1);
    check("dm_valid_a5", transport_data_valid, 1);
    check("dm_data_a5", transport_layer_data_out, 8'hA5);
    @(negedge fsm_clk);
    check("dm_valid_pulse", transport_data_valid, 0);
    send_byte(8'h3C, 2);
    check("dm_valid_3c", transport_data_valid, 1);
    check("dm_data_3c", transport_layer_data_out, 8'h3C);
    load8(64'h01010000000064F2);
    run_seq(8);
    check("dm_no_os", ov_count, 0);
    data_mode = 1'b0;
    run_seq(8);
    check("dm_exit_count", ov_count, 1);
    check("dm_exit_code", ov_code, 2);

    // Reset in the middle of a Gen3 TS1
    do_reset();
    load8(64'h01010000000064F2);
    for (int i = 0; i < 5; i++) send_byte(seq[i], i + 1);
    do_reset();
    run_seq(8);
    check("midrst_count", ov_count, 1);
    check("midrst_code", ov_code, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
